// File: rtl/fft_stereo_sequencer.sv
// Shares one streaming FFT core between left and right audio channels:
// captures stereo pairs into two frame banks and streams each full bank as a left frame then a right frame.
module fft_stereo_sequencer #(
  parameter int N_POINTS = 64,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  output logic              sample_drop,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic [1:0]        sink_error,
  input  logic              source_valid,
  input  logic              source_sop,
  input  logic              source_eop,
  output logic              out_channel,
  output logic              stereo_done,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W-1:0] ZERO = '0;

  logic [DATA_W-1:0] left_mem  [2*N_POINTS];
  logic [DATA_W-1:0] right_mem [2*N_POINTS];

  state_t            state;
  logic              wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]        bank_full;

  logic              xfer, at_last, release_bank, accept, fill_done;
  logic [ADDR_W-1:0] rd_next;
  logic [1:0]        set_mask, clr_mask;
  logic              unused_source_sop;

  assign xfer         = sink_valid & sink_ready;
  assign at_last      = (rd_ptr == LAST);
  assign rd_next      = rd_ptr + 1'b1;
  assign release_bank = (state == S_RIGHT) & xfer & at_last;
  // A bank released on this very edge may take the incoming pair.
  assign accept       = sample_valid &
                        (~bank_full[wr_bank] | (release_bank & (rd_bank == wr_bank)));
  assign fill_done    = accept & (wr_ptr == LAST);
  assign set_mask     = fill_done    ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask     = release_bank ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  assign busy              = (|bank_full) | (state != S_IDLE);
  assign sink_imag         = '0;
  assign sink_error        = 2'b00;
  assign unused_source_sop = source_sop;

  // NOTE: frame memories are never read before written, so they carry no reset and map to plain RAM.
  always_ff @(posedge clock) begin
    if (accept) begin
      left_mem[{wr_bank, wr_ptr}]  <= sample_left;
      right_mem[{wr_bank, wr_ptr}] <= sample_right;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_bank     <= 1'b0;
      wr_ptr      <= '0;
      sample_drop <= 1'b0;
      bank_full   <= 2'b00;
    end else begin
      sample_drop <= sample_valid & ~accept;
      bank_full   <= (bank_full & ~clr_mask) | set_mask;
      if (accept) begin
        if (wr_ptr == LAST) begin
          wr_bank <= ~wr_bank;
          wr_ptr  <= '0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_bank    <= 1'b0;
      rd_ptr     <= '0;
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
      sink_real  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bank_full[rd_bank]) begin
            state      <= S_LEFT;
            rd_ptr     <= '0;
            sink_real  <= left_mem[{rd_bank, ZERO}];
            sink_valid <= 1'b1;
            sink_sop   <= 1'b1;
            sink_eop   <= 1'b0;
          end
        end
        S_LEFT: begin
          if (xfer) begin
            if (at_last) begin
              // Right frame follows the left eop with no gap cycle.
              state     <= S_RIGHT;
              rd_ptr    <= '0;
              sink_real <= right_mem[{rd_bank, ZERO}];
              sink_sop  <= 1'b1;
              sink_eop  <= 1'b0;
            end else begin
              rd_ptr    <= rd_next;
              sink_real <= left_mem[{rd_bank, rd_next}];
              sink_sop  <= 1'b0;
              sink_eop  <= (rd_next == LAST);
            end
          end
        end
        S_RIGHT: begin
          if (xfer) begin
            if (at_last) begin
              state      <= S_IDLE;
              rd_ptr     <= '0;
              rd_bank    <= ~rd_bank;
              sink_valid <= 1'b0;
              sink_sop   <= 1'b0;
              sink_eop   <= 1'b0;
            end else begin
              rd_ptr    <= rd_next;
              sink_real <= right_mem[{rd_bank, rd_next}];
              sink_sop  <= 1'b0;
              sink_eop  <= (rd_next == LAST);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Channel tag flips at each output eop so it is already correct at the next sop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_channel <= 1'b0;
      stereo_done <= 1'b0;
    end else begin
      stereo_done <= source_valid & source_eop & out_channel;
      if (source_valid & source_eop) out_channel <= ~out_channel;
    end
  end

endmodule

// File: tb/tb_fft_stereo_sequencer.sv
// Self-checking bench for fft_stereo_sequencer with N_POINTS=8: scoreboard of FFT sink words
// plus a table of output-tagging vectors and hand-written corner sequences.
module tb_fft_stereo_sequencer;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] real_v;
    logic          sop;
    logic          eop;
  } word_t;

  typedef struct {
    logic v;
    logic sop;
    logic eop;
    logic exp_ch;
    logic exp_done;
  } tag_vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [DW-1:0] sample_left, sample_right;
  logic          sample_drop;
  logic          sink_ready;
  logic          sink_valid, sink_sop, sink_eop;
  logic [DW-1:0] sink_real, sink_imag;
  logic [1:0]    sink_error;
  logic          source_valid, source_sop, source_eop;
  logic          out_channel, stereo_done, busy;

  fft_stereo_sequencer #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .sample_valid(sample_valid), .sample_left(sample_left), .sample_right(sample_right),
    .sample_drop(sample_drop),
    .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_error(sink_error),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .out_channel(out_channel), .stereo_done(stereo_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int    total = 0;
  int    bad   = 0;
  word_t exp_q[$];
  bit    mon_en = 1'b0;
  int    cyc = 0, xfer_cnt = 0, first_cyc = 0, last_cyc = 0, drop_cnt = 0;
  bit    stall_prev = 1'b0;
  logic [DW-1:0] held_real;
  logic          held_sop, held_eop;
  word_t         mon_w;
  tag_vec_t      tag_tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: samples at the falling edge, i.e. just before the edge that performs a transfer.
  always @(negedge clock) begin
    cyc++;
    if (mon_en && !reset) begin
      if (stall_prev) begin
        check("hold_valid", sink_valid, 1);
        check("hold_real",  sink_real,  held_real);
        check("hold_sop",   sink_sop,   held_sop);
        check("hold_eop",   sink_eop,   held_eop);
      end
      if (sink_valid && sink_ready) begin
        check("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_w = exp_q.pop_front();
          check("sink_real", sink_real, mon_w.real_v);
          check("sink_sop",  sink_sop,  mon_w.sop);
          check("sink_eop",  sink_eop,  mon_w.eop);
        end
        if (xfer_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_cnt++;
      end
      if (sample_drop) drop_cnt++;
      stall_prev = sink_valid && !sink_ready;
      held_real  = sink_real;
      held_sop   = sink_sop;
      held_eop   = sink_eop;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Drives N consecutive pairs; when push is set the expected left then right frame is queued.
  task automatic drive_frame(input int base, input bit push);
    word_t w;
    if (push) begin
      for (int k = 0; k < N; k++) begin
        w.real_v = 16'(base + k); w.sop = (k == 0); w.eop = (k == N - 1);
        exp_q.push_back(w);
      end
      for (int k = 0; k < N; k++) begin
        w.real_v = 16'(base + 100 + k); w.sop = (k == 0); w.eop = (k == N - 1);
        exp_q.push_back(w);
      end
    end
    for (int k = 0; k < N; k++) begin
      @(posedge clock); #1;
      sample_valid = 1'b1;
      sample_left  = 16'(base + k);
      sample_right = 16'(base + 100 + k);
    end
    @(posedge clock); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check(name, n < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat[4];
    int   n;
    bit   found;
    word_t w;

    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    //               v     sop   eop   ch    done
    tag_tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tag_tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tag_tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tag_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tag_tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tag_tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tag_tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tag_tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tag_tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tag_tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; sample_valid = 1'b0; sample_left = '0; sample_right = '0;
    sink_ready = 1'b1; source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
    #1;
    check("rst_sink_valid", sink_valid, 0);
    check("rst_sink_sop", sink_sop, 0);
    check("rst_sink_eop", sink_eop, 0);
    check("rst_sink_real", sink_real, 0);
    check("rst_sample_drop", sample_drop, 0);
    check("rst_stereo_done", stereo_done, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_busy", busy, 0);
    check("sink_imag", sink_imag, 0);
    check("sink_error", sink_error, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Fill and stream at full rate.
    xfer_cnt = 0; drop_cnt = 0;
    drive_frame(0, 1'b1);
    wait_drain("fill_drain", 200);
    check("fill_xfers", xfer_cnt, 16);
    check("fill_consecutive", last_cyc - first_cyc, 15);
    check("fill_valid_low", sink_valid, 0);
    check("fill_no_drop", drop_cnt, 0);

    // Backpressure with sink_ready pattern 1,0,0,1.
    xfer_cnt = 0;
    fork
      drive_frame(200, 1'b1);
    join_none
    @(posedge clock); #1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      sink_ready = pat[n % 4];
      @(posedge clock); #1;
      n++;
    end
    check("bp_drain", n < 400, 1);
    sink_ready = 1'b1;
    check("bp_xfers", xfer_cnt, 16);
    check("bp_no_drop", drop_cnt, 0);

    // Overflow: sink stalled, 24 pairs, the last 8 are dropped.
    sink_ready = 1'b0; drop_cnt = 0;
    drive_frame(300, 1'b1);
    drive_frame(400, 1'b1);
    drive_frame(500, 1'b0);
    repeat (2) @(posedge clock); #1;
    check("ovf_drops", drop_cnt, 8);
    check("ovf_busy", busy, 1);
    check("ovf_valid", sink_valid, 1);
    check("ovf_sop", sink_sop, 1);
    check("ovf_first_word", sink_real, 300);
    sink_ready = 1'b1;
    wait_drain("ovf_drain", 200);

    // Collision: 17th pair lands on the bank-0 right eop transfer.
    sink_ready = 1'b0; drop_cnt = 0;
    drive_frame(600, 1'b1);
    drive_frame(2000, 1'b1);
    repeat (2) @(posedge clock); #1;
    for (int k = 0; k < N; k++) begin
      w.real_v = 16'(3000 + k); w.sop = (k == 0); w.eop = (k == N - 1);
      exp_q.push_back(w);
    end
    for (int k = 0; k < N; k++) begin
      w.real_v = 16'(3100 + k); w.sop = (k == 0); w.eop = (k == N - 1);
      exp_q.push_back(w);
    end
    sink_ready = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    check("coll_eop_aligned", sink_eop, 1);
    check("coll_eop_word", sink_real, 707);
    for (int k = 0; k < N; k++) begin
      sample_valid = 1'b1;
      sample_left  = 16'(3000 + k);
      sample_right = 16'(3100 + k);
      @(posedge clock); #1;
    end
    sample_valid = 1'b0;
    wait_drain("coll_drain", 300);
    check("coll_no_drop", drop_cnt, 0);

    // Output tagging from the vector table.
    for (int i = 0; i < 10; i++) begin
      source_valid = tag_tbl[i].v;
      source_sop   = tag_tbl[i].sop;
      source_eop   = tag_tbl[i].eop;
      @(posedge clock); #1;
      check($sformatf("tag_ch_%0d", i), out_channel, tag_tbl[i].exp_ch);
      check($sformatf("tag_done_%0d", i), stereo_done, tag_tbl[i].exp_done);
    end
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;

    // Asynchronous reset in the middle of a right frame.
    mon_en = 1'b0;
    drive_frame(1000, 1'b0);
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clock);
      if (sink_valid && sink_real == 16'd1103) found = 1'b1;
      n++;
    end
    check("arst_reached_word3", found, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", sink_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_sop", sink_sop, 0);
    check("arst_real", sink_real, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    drop_cnt = 0; xfer_cnt = 0;
    mon_en = 1'b1;
    drive_frame(1200, 1'b1);
    wait_drain("arst_drain", 200);
    check("arst_xfers", xfer_cnt, 16);
    check("arst_no_drop", drop_cnt, 0);
    check("arst_end_valid", sink_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
